reg_read_arbiter: RTL and testbench

Shares the single 17:1 register-file read mux (reg0-reg15 plus pc) between up to PA_NUM_REQ requesters, such as operand A/B/C fetch and store-data fetch.
Arbitrates round-robin, drives the mux 9-bit select, waits for the mux acknowledge, and returns the captured read data to the winning requester with a one-cycle valid pulse.
Sits between the decode/issue logic and the register read mux.

---
 rtl/janus_pkg.sv | 27 ++
 rtl/reg_read_arbiter_rr_arbiter.sv | 36 +++
 rtl/reg_read_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_read_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/janus_pkg.sv
// Shared definitions for the register read path: the index encoding, the mux
// select encoding and the read-arbiter FSM state encoding.
package janus_pkg;

    localparam int REG_IDX_W = 5;
    localparam int MAX_IDX   = 16;
    localparam logic [REG_IDX_W-1:0] PC_IDX = REG_IDX_W'(MAX_IDX);

    localparam int SEL_W = 9;
    localparam logic [SEL_W-1:0] SEL_IDLE = 9'h100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RESP     = 2'd2
    } arb_state_e;

    // reg0-reg15 plus pc are the only indices the mux can serve.
    function automatic logic idx_valid(input logic [REG_IDX_W-1:0] idx);
        return idx <= PC_IDX;
    endfunction

    function automatic logic [SEL_W-1:0] sel_for(input logic [REG_IDX_W-1:0] idx);
        return {1'b0, 3'b000, idx};
    endfunction

endpackage

// File: rtl/reg_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the lowest set request at or above ptr
// wins; if there is none, the lowest set request below ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        // NOTE: every output gets a default before the search, so no path through the block leaves one unassigned and no latch is inferred.
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[i] && (PTR_W'(i) >= ptr)) begin
                gnt_any    = 1'b1;
                gnt_oh[i]  = 1'b1;
                gnt_idx    = PTR_W'(i);
            end
        end
        // Wrapped half of the search: slots below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[i] && (PTR_W'(i) < ptr)) begin
                gnt_any    = 1'b1;
                gnt_oh[i]  = 1'b1;
                gnt_idx    = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter sharing the 17:1 register read mux between PA_NUM_REQ
// requesters. Define REG_ARB_TIMEOUT_EN to bound the wait for mux_ack.
module reg_read_arbiter
    import janus_pkg::*;
#(
    parameter int PA_DATA_WIDTH = 32,
    parameter int PA_NUM_REQ    = 4,
    parameter int PA_TIMEOUT    = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PA_NUM_REQ-1:0]             req,
    input  logic [PA_NUM_REQ*REG_IDX_W-1:0]   req_idx,
    output logic [SEL_W-1:0]                  mux_sel,
    input  logic [PA_DATA_WIDTH-1:0]          mux_out,
    input  logic                              mux_ack,
    output logic [PA_DATA_WIDTH-1:0]          rd_data,
    output logic [PA_NUM_REQ-1:0]             rd_valid,
    output logic                              rd_err,
    output logic                              busy
);

    localparam int PTR_W = $clog2(PA_NUM_REQ);

    if (PA_NUM_REQ < 2 || PA_NUM_REQ > 8) begin : g_bad_num_req
        $error("reg_read_arbiter: PA_NUM_REQ must be 2..8");
    end
    // The wait counter is 4 bits wide, so the limit must fit in it.
    if (PA_TIMEOUT < 1 || PA_TIMEOUT > 15) begin : g_bad_timeout
        $error("reg_read_arbiter: PA_TIMEOUT must be 1..15");
    end

    arb_state_e                state, state_nxt;
    logic [PTR_W-1:0]          rr_ptr, rr_ptr_nxt;
    logic [PA_NUM_REQ-1:0]     gnt, gnt_nxt;
    logic [SEL_W-1:0]          mux_sel_nxt;
    logic [PA_DATA_WIDTH-1:0]  rd_data_nxt;
    logic [PA_NUM_REQ-1:0]     rd_valid_nxt;
    logic                      rd_err_nxt;
    logic                      busy_nxt;
    logic                      timed_out;

    logic [PA_NUM_REQ-1:0]     win_oh;
    logic [PTR_W-1:0]          win_idx;
    logic                      win_any;
    logic [REG_IDX_W-1:0]      win_reg;

    rr_arbiter #(
        .N     (PA_NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_oh  (win_oh),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    always_comb begin
        win_reg = '0;
        for (int i = 0; i < PA_NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_reg = req_idx[i*REG_IDX_W +: REG_IDX_W];
            end
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt, wait_cnt_nxt;

    // Counts the WAIT_ACK cycles that passed without an acknowledge.
    assign timed_out = (state == ST_WAIT_ACK) && !mux_ack
                    && (wait_cnt == 4'(PA_TIMEOUT - 1));

    always_comb begin
        wait_cnt_nxt = '0;
        if (state == ST_WAIT_ACK && !mux_ack) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // State register; every output is registered alongside it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            mux_sel  <= SEL_IDLE;
            rd_data  <= '0;
            rd_valid <= '0;
            rd_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt      <= gnt_nxt;
            mux_sel  <= mux_sel_nxt;
            rd_data  <= rd_data_nxt;
            rd_valid <= rd_valid_nxt;
            rd_err   <= rd_err_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (win_any) begin
                    state_nxt = idx_valid(win_reg) ? ST_WAIT_ACK : ST_RESP;
                end
            end
            ST_WAIT_ACK: begin
                if (mux_ack || timed_out) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and grant bookkeeping.
    always_comb begin
        mux_sel_nxt  = mux_sel;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = '0;
        rd_err_nxt   = 1'b0;
        gnt_nxt      = gnt;
        rr_ptr_nxt   = rr_ptr;
        busy_nxt     = (state_nxt != ST_IDLE);
        case (state)
            ST_IDLE: begin
                mux_sel_nxt = SEL_IDLE;
                if (win_any) begin
                    gnt_nxt    = win_oh;
                    rr_ptr_nxt = (win_idx == PTR_W'(PA_NUM_REQ - 1)) ? '0
                                                                     : win_idx + PTR_W'(1);
                    if (idx_valid(win_reg)) begin
                        mux_sel_nxt = sel_for(win_reg);
                    end else begin
                        // Bad index: answer at once with an error, mux stays parked.
                        rd_valid_nxt = win_oh;
                        rd_err_nxt   = 1'b1;
                        rd_data_nxt  = '0;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (mux_ack) begin
                    rd_data_nxt  = mux_out;
                    mux_sel_nxt  = SEL_IDLE;
                    rd_valid_nxt = gnt;
                end else if (timed_out) begin
                    rd_data_nxt  = '0;
                    mux_sel_nxt  = SEL_IDLE;
                    rd_valid_nxt = gnt;
                    rd_err_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Bench for reg_read_arbiter: directed scenarios and random traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_reg_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef REG_ARB_TIMEOUT_EN
    localparam int TMO = 15;
`else
    localparam int TMO = 1 << 30;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*5-1:0] req_idx;
    logic [8:0]     mux_sel;
    logic [DW-1:0]  mux_out;
    logic           mux_ack;
    logic [DW-1:0]  rd_data;
    logic [N-1:0]   rd_valid;
    logic           rd_err;
    logic           busy;

    reg_read_arbiter #(
        .PA_DATA_WIDTH (DW),
        .PA_NUM_REQ    (N),
        .PA_TIMEOUT    (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_idx  (req_idx),
        .mux_sel  (mux_sel),
        .mux_out  (mux_out),
        .mux_ack  (mux_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural register file behind the mux; a parked or bogus select returns junk.
    logic [DW-1:0] regfile [0:16];
    assign mux_out = (mux_sel[8] || mux_sel[4:0] > 5'd16) ? 32'hDEAD_BEEF
                                                          : regfile[mux_sel[4:0]];

    typedef struct {
        logic [8:0]    sel;
        logic [N-1:0]  valid;
        logic          err;
        logic          busy;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expq[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [N-1:0]  want;
    logic [4:0]    want_idx [N];
    int            m_ptr, ack_at, win_lo, win_hi, cur_gnt;
    int            ack_delay_cfg, resp_policy;
    bit            rand_mode, noise_en;
    logic [DW-1:0] last_data;
    int            obs_q[$];
    int            fair_exp [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] sel, input logic [N-1:0] valid,
                                input logic err, input logic bsy, input logic [DW-1:0] data);
        exp_t e;
        e.sel = sel; e.valid = valid; e.err = err; e.busy = bsy; e.data = data;
        return e;
    endfunction

    function automatic logic [4:0] rand_idx();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(17, 31));
        return 5'($urandom_range(0, 16));
    endfunction

    // Model of one arbitration decision taken while the arbiter is idle:
    // queues the expected outputs for every following cycle of the transaction.
    task automatic model_issue();
        int g, d, wait_n;
        logic [4:0]   idx;
        logic [N-1:0] oh;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && want[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        if (g < 0) begin
            expq.push_back(mk(9'h100, '0, 1'b0, 1'b0, last_data));
            return;
        end
        m_ptr   = (g + 1) % N;
        idx     = want_idx[g];
        oh      = N'(1) << g;
        cur_gnt = g;
        if (idx > 5'd16) begin
            ack_at    = -1;
            last_data = '0;
            expq.push_back(mk(9'h100, oh, 1'b1, 1'b1, '0));
            expq.push_back(mk(9'h100, '0, 1'b0, 1'b0, last_data));
            return;
        end
        if (ack_delay_cfg >= 0) d = ack_delay_cfg;
        else d = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 4));
        if (d >= TMO) begin
            wait_n = TMO;
            ack_at = -1;
        end else begin
            wait_n = d + 1;
            ack_at = cyc + 1 + d;
        end
        win_lo = cyc + 1;
        win_hi = cyc + wait_n;
        repeat (wait_n) expq.push_back(mk({4'b0000, idx}, '0, 1'b0, 1'b1, last_data));
        if (d >= TMO) begin
            last_data = '0;
            expq.push_back(mk(9'h100, oh, 1'b1, 1'b1, '0));
        end else begin
            last_data = regfile[idx];
            expq.push_back(mk(9'h100, oh, 1'b0, 1'b1, last_data));
        end
        expq.push_back(mk(9'h100, '0, 1'b0, 1'b0, last_data));
    endtask

    // One clock cycle: check this cycle's outputs, let requesters react, then
    // drive the inputs for the next rising edge.
    task automatic step(input bit do_rst);
        exp_t e;
        @(negedge clk);
        cyc++;
        e = expq.pop_front();
        check("mux_sel",  mux_sel,  e.sel);
        check("rd_valid", rd_valid, e.valid);
        check("rd_err",   rd_err,   e.err);
        check("busy",     busy,     e.busy);
        check("rd_data",  rd_data,  e.data);
        for (int i = 0; i < N; i++) if (rd_valid[i] === 1'b1) obs_q.push_back(i);

        for (int i = 0; i < N; i++) begin
            if (e.valid[i]) begin
                cur_gnt = -1;
                if (resp_policy == 0) begin
                    want[i] = 1'b0;
                end else if (resp_policy == 2) begin
                    if ($urandom_range(0, 1) == 0) want[i] = 1'b0;
                    else begin
                        want[i]     = 1'b1;
                        want_idx[i] = rand_idx();
                    end
                end
            end
        end
        if (rand_mode) begin
            if (cur_gnt >= 0 && $urandom_range(0, 15) == 0) want[cur_gnt] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 3) == 0) begin
                    want[i]     = 1'b1;
                    want_idx[i] = rand_idx();
                end
            end
        end

        if (do_rst) begin
            rst = 1'b1;
            expq.delete();
            expq.push_back(mk(9'h100, '0, 1'b0, 1'b0, '0));
            m_ptr = 0; last_data = '0; ack_at = -1; win_lo = -1; win_hi = -1; cur_gnt = -1;
        end else begin
            rst = 1'b0;
            if (expq.size() == 0) model_issue();
        end

        req = want;
        for (int i = 0; i < N; i++) req_idx[i*5 +: 5] = want_idx[i];
        mux_ack = (cyc == ack_at)
               || (noise_en && !(cyc >= win_lo && cyc <= win_hi) && $urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_idx = '0; mux_ack = 1'b0; want = '0;
        for (int i = 0; i < N; i++) want_idx[i] = '0;
        for (int i = 0; i <= 16; i++) regfile[i] = $urandom();
        regfile[0]  = 32'h0000_0000;
        regfile[1]  = 32'h1111_1111;
        regfile[3]  = 32'h3333_3333;
        regfile[12] = 32'hCCCC_CCCC;
        regfile[15] = 32'hFFFF_FFFF;
        regfile[16] = 32'hABAB_ABAB;
        m_ptr = 0; ack_at = -1; win_lo = -1; win_hi = -1; cur_gnt = -1;
        ack_delay_cfg = 0; resp_policy = 0; rand_mode = 1'b0; noise_en = 1'b0;
        last_data = '0;
        expq.push_back(mk(9'h100, '0, 1'b0, 1'b0, '0));

        // Reset state.
        step(1'b1);
        step(1'b1);

        // Single read of reg3, acknowledged on the first WAIT_ACK cycle.
        want[0] = 1'b1; want_idx[0] = 5'd3;
        repeat (6) step(1'b0);

        // Fairness: all four requesters held high after a fresh reset.
        step(1'b1);
        obs_q.delete();
        want = '1;
        want_idx[0] = 5'd0; want_idx[1] = 5'd1; want_idx[2] = 5'd15; want_idx[3] = 5'd16;
        resp_policy = 1;
        repeat (15) step(1'b0);
        want = '0;
        resp_policy = 0;
        repeat (4) step(1'b0);
        while (obs_q.size() < 5) obs_q.push_back(-1);
        for (int i = 0; i < 5; i++) check($sformatf("fair_gnt%0d", i), obs_q[i], fair_exp[i]);

        // Invalid index answers with an error without touching the mux.
        want[2] = 1'b1; want_idx[2] = 5'd20;
        repeat (4) step(1'b0);

        // Delayed acknowledge with stray acks while idle.
        ack_delay_cfg = 5; noise_en = 1'b1;
        want[1] = 1'b1; want_idx[1] = 5'd12;
        repeat (10) step(1'b0);
        noise_en = 1'b0;

        // Reset during WAIT_ACK, request still high afterwards.
        ack_delay_cfg = 10;
        want[1] = 1'b1; want_idx[1] = 5'd7;
        repeat (3) step(1'b0);
        step(1'b1);
        ack_delay_cfg = 0;
        repeat (6) step(1'b0);

        // Acknowledge held off for 40 cycles: times out only when the feature is built in.
        ack_delay_cfg = 40;
        want[3] = 1'b1; want_idx[3] = 5'd16;
        repeat (45) step(1'b0);

        // Random traffic.
        ack_delay_cfg = -1; resp_policy = 2; rand_mode = 1'b1; noise_en = 1'b1;
        repeat (800) step($urandom_range(0, 99) == 0);
        rand_mode = 1'b0; resp_policy = 0; want = '0;
        repeat (60) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
